gpio_cfg_rx: RTL and testbench

- Per-pad receiver for the serial GPIO configuration chain driven by the user-project control block's serial loader.
- Oversamples serial_clock, serial_resetn and serial data in the core clock domain and shifts IO_CTRL_BITS bits per pad.
- On the load pulse, latches the shifted word into the pad configuration register and decodes it into pad control fields.
- Re-times the chain signals and forwards them to the next pad's instance, so any number of pads can be cascaded.

---
 rtl/gpio_cfg_rx.sv | 145 ++++++++++++++
 tb/tb_gpio_cfg_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cfg_rx.sv
// Per-pad receiver of the serial GPIO configuration chain.
// Latency: chain clock/reset/data re-timed with 3 clk; cfg_word updates 1 clk after the synchronised load edge.
// Backpressure: none; the chain is free-running and each level must be held for at least one clk.
//
// Ports: clk/resetn (async active-low); serial_*_in from upstream, serial_*_out to the next pad;
//        cfg_word is the latched word, the single-bit and dm outputs decode it; cfg_updated pulses on load.
module gpio_cfg_rx #(
    parameter int                      IO_CTRL_BITS = 13,
    parameter logic [IO_CTRL_BITS-1:0] CFG_DEFAULT  = 13'h0403
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    serial_clock_in,
    input  logic                    serial_resetn_in,
    input  logic                    serial_data_in,
    output logic                    serial_clock_out,
    output logic                    serial_resetn_out,
    output logic                    serial_data_out,
    output logic [IO_CTRL_BITS-1:0] cfg_word,
    output logic                    mgmt_ena,
    output logic                    gpio_oeb,
    output logic                    hold_override,
    output logic                    inp_dis,
    output logic                    ib_sel,
    output logic                    analog_en,
    output logic                    analog_sel,
    output logic                    analog_pol,
    output logic                    slow_sel,
    output logic                    vtrip_sel,
    output logic [2:0]              dm,
    output logic                    cfg_updated
);

    // Two-flop synchronisers (meta -> sync) plus a third "prev" flop per
    // strobe line for edge detection. The prev flops double as the re-timed
    // chain outputs, giving 3 clk of latency from pin to next pad.
    logic clk_meta_q,  clk_meta_d;
    logic clk_sync_q,  clk_sync_d;
    logic clk_prev_q,  clk_prev_d;
    logic rstn_meta_q, rstn_meta_d;
    logic rstn_sync_q, rstn_sync_d;
    logic rstn_prev_q, rstn_prev_d;
    logic data_meta_q, data_meta_d;
    logic data_sync_q, data_sync_d;

    logic [IO_CTRL_BITS-1:0] shift_q,    shift_d;
    logic [IO_CTRL_BITS-1:0] cfg_word_q, cfg_word_d;
    logic                    data_out_q, data_out_d;
    logic                    cfg_updated_q, cfg_updated_d;

    logic rise, fall, ldn, clear, load;

    always_comb begin
        rise  = clk_sync_q & ~clk_prev_q;
        fall  = ~clk_sync_q & clk_prev_q;
        ldn   = ~rstn_sync_q & rstn_prev_q;
        // Chain reset held with the clock low wipes the partial word but
        // keeps the latched configuration (loader sitting in reset).
        clear = ~rstn_sync_q & ~clk_sync_q;
        // A falling strobe only loads while the chain clock is high; with the
        // clock low it is just the start of a clear.
        load  = ldn & clk_sync_q;

        clk_meta_d  = serial_clock_in;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        rstn_meta_d = serial_resetn_in;
        rstn_sync_d = rstn_meta_q;
        rstn_prev_d = rstn_sync_q;
        data_meta_d = serial_data_in;
        data_sync_d = data_meta_q;

        shift_d = shift_q;
        if (clear) begin
            shift_d = '0;
        end else if (rise && rstn_sync_q) begin
            shift_d = {shift_q[IO_CTRL_BITS-2:0], data_sync_q};
        end

        // Data to the next pad moves with the falling chain clock so it is
        // settled well before the downstream rising edge.
        data_out_d = data_out_q;
        if (clear) begin
            data_out_d = 1'b0;
        end else if (fall) begin
            data_out_d = shift_q[IO_CTRL_BITS-1];
        end

        cfg_word_d    = cfg_word_q;
        cfg_updated_d = 1'b0;
        if (load) begin
            cfg_word_d    = shift_q;
            cfg_updated_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_meta_q    <= 1'b0;
            clk_sync_q    <= 1'b0;
            clk_prev_q    <= 1'b0;
            rstn_meta_q   <= 1'b0;
            rstn_sync_q   <= 1'b0;
            rstn_prev_q   <= 1'b0;
            data_meta_q   <= 1'b0;
            data_sync_q   <= 1'b0;
            shift_q       <= '0;
            cfg_word_q    <= CFG_DEFAULT;
            data_out_q    <= 1'b0;
            cfg_updated_q <= 1'b0;
        end else begin
            clk_meta_q    <= clk_meta_d;
            clk_sync_q    <= clk_sync_d;
            clk_prev_q    <= clk_prev_d;
            rstn_meta_q   <= rstn_meta_d;
            rstn_sync_q   <= rstn_sync_d;
            rstn_prev_q   <= rstn_prev_d;
            data_meta_q   <= data_meta_d;
            data_sync_q   <= data_sync_d;
            shift_q       <= shift_d;
            cfg_word_q    <= cfg_word_d;
            data_out_q    <= data_out_d;
            cfg_updated_q <= cfg_updated_d;
        end
    end

    assign serial_clock_out  = clk_prev_q;
    assign serial_resetn_out = rstn_prev_q;
    assign serial_data_out   = data_out_q;
    assign cfg_word          = cfg_word_q;
    assign cfg_updated       = cfg_updated_q;

    assign mgmt_ena      = cfg_word_q[0];
    assign gpio_oeb      = cfg_word_q[1];
    assign hold_override = cfg_word_q[2];
    assign inp_dis       = cfg_word_q[3];
    assign ib_sel        = cfg_word_q[4];
    assign analog_en     = cfg_word_q[5];
    assign analog_sel    = cfg_word_q[6];
    assign analog_pol    = cfg_word_q[7];
    assign slow_sel      = cfg_word_q[8];
    assign vtrip_sel     = cfg_word_q[9];
    assign dm            = cfg_word_q[12:10];

endmodule

// File: tb/tb_gpio_cfg_rx.sv
// Bench for gpio_cfg_rx: two cascaded pads driven by a directed serial loader.
// Latency: measured against the 3 clk per hop forwarding delay.
// Backpressure: not applicable; stimulus paces the chain at one level per clk.
module tb_gpio_cfg_rx;
    localparam int W = 13;

    logic clk = 1'b0;
    logic resetn;
    logic sck_in, srn_in, sd_in;

    logic sck0, srn0, sd0, upd0;
    logic [W-1:0] cfg0;
    logic mgmt0, oeb0, hold0, inp0, ib0, aen0, asel0, apol0, slow0, vtrip0;
    logic [2:0] dm0;

    logic sck1, srn1, sd1, upd1;
    logic [W-1:0] cfg1;
    logic mgmt1, oeb1, hold1, inp1, ib1, aen1, asel1, apol1, slow1, vtrip1;
    logic [2:0] dm1;

    always #5 clk = ~clk;

    gpio_cfg_rx #(.IO_CTRL_BITS(W), .CFG_DEFAULT(13'h0403)) u_pad0 (
        .clk(clk), .resetn(resetn),
        .serial_clock_in(sck_in), .serial_resetn_in(srn_in), .serial_data_in(sd_in),
        .serial_clock_out(sck0), .serial_resetn_out(srn0), .serial_data_out(sd0),
        .cfg_word(cfg0), .mgmt_ena(mgmt0), .gpio_oeb(oeb0), .hold_override(hold0),
        .inp_dis(inp0), .ib_sel(ib0), .analog_en(aen0), .analog_sel(asel0),
        .analog_pol(apol0), .slow_sel(slow0), .vtrip_sel(vtrip0), .dm(dm0),
        .cfg_updated(upd0)
    );

    gpio_cfg_rx #(.IO_CTRL_BITS(W), .CFG_DEFAULT(13'h1803)) u_pad1 (
        .clk(clk), .resetn(resetn),
        .serial_clock_in(sck0), .serial_resetn_in(srn0), .serial_data_in(sd0),
        .serial_clock_out(sck1), .serial_resetn_out(srn1), .serial_data_out(sd1),
        .cfg_word(cfg1), .mgmt_ena(mgmt1), .gpio_oeb(oeb1), .hold_override(hold1),
        .inp_dis(inp1), .ib_sel(ib1), .analog_en(aen1), .analog_sel(asel1),
        .analog_pol(apol1), .slow_sel(slow1), .vtrip_sel(vtrip1), .dm(dm1),
        .cfg_updated(upd1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reassemble the decoded field outputs in bit order of cfg_word.
    function automatic logic [W-1:0] fields0();
        return {dm0, vtrip0, slow0, apol0, asel0, aen0, ib0, inp0, hold0, oeb0, mgmt0};
    endfunction
    function automatic logic [W-1:0] fields1();
        return {dm1, vtrip1, slow1, apol1, asel1, aen1, ib1, inp1, hold1, oeb1, mgmt1};
    endfunction

    // Background monitor: cfg_updated high-cycle counts and data-out changes
    // that are not accompanied by a falling forwarded clock.
    logic mon_en = 1'b0;
    int   upd0_cycles = 0, upd1_cycles = 0;
    int   dout_viol = 0, dout_changes0 = 0;
    logic prev_sck0 = 1'b0, prev_sd0 = 1'b0, prev_sck1 = 1'b0, prev_sd1 = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (upd0) upd0_cycles++;
            if (upd1) upd1_cycles++;
            if (sd0 !== prev_sd0) begin
                dout_changes0++;
                if (!(prev_sck0 === 1'b1 && sck0 === 1'b0)) dout_viol++;
            end
            if (sd1 !== prev_sd1 && !(prev_sck1 === 1'b1 && sck1 === 1'b0)) dout_viol++;
        end
        prev_sck0 = sck0;
        prev_sd0  = sd0;
        prev_sck1 = sck1;
        prev_sd1  = sd1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sck_in = 1'b0;
        sd_in  = b;
        step(1);
        sck_in = 1'b1;
        step(1);
    endtask

    // MSB-first, first nbits bits of w.
    task automatic send_word(input logic [W-1:0] w, input int nbits);
        for (int i = W - 1; i >= W - nbits; i--) send_bit(w[i]);
    endtask

    task automatic load_strobe();
        sck_in = 1'b1;
        step(2);
        srn_in = 1'b0;
        step(2);
        sck_in = 1'b0;
        step(2);
        srn_in = 1'b1;
        step(2);
    endtask

    int base0, base1, lat, lat0, lat1;

    initial begin
        resetn = 1'b0;
        sck_in = 1'b0;
        srn_in = 1'b1;
        sd_in  = 1'b0;
        step(3);

        // Reset state
        check_eq("rst_cfg0",   32'(cfg0), 32'h0403);
        check_eq("rst_cfg1",   32'(cfg1), 32'h1803);
        check_eq("rst_fields0", 32'({dm0, inp0, oeb0, mgmt0}), 32'b001_0_1_1);
        check_eq("rst_outs0",  32'({sck0, srn0, sd0, upd0}), 32'h0);

        resetn = 1'b1;
        step(4);
        mon_en = 1'b1;

        // Single-pad load of 13'h1803, measuring strobe-to-pulse latency
        base0 = upd0_cycles;
        send_word(13'h1803, W);
        step(6);
        sck_in = 1'b1;
        step(2);
        srn_in = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (upd0 === 1'b1 && lat < 0) lat = i;
        end
        check_eq("load_latency_3to5", 32'(lat >= 3 && lat <= 5), 32'h1);
        sck_in = 1'b0;
        step(2);
        srn_in = 1'b1;
        step(8);
        check_eq("single_cfg0",  32'(cfg0), 32'h1803);
        check_eq("single_pulse", 32'(upd0_cycles - base0), 32'h1);
        check_eq("single_dec",   32'({dm0, oeb0}), 32'b110_1);
        check_eq("single_cfg1",  32'(cfg1), 32'h0000);

        // Two-pad chain: first word lands in the far pad
        base0 = upd0_cycles;
        base1 = upd1_cycles;
        send_word(13'h0ABC, W);
        send_word(13'h1555, W);
        step(8);
        load_strobe();
        step(8);
        check_eq("chain_cfg0",    32'(cfg0), 32'h1555);
        check_eq("chain_cfg1",    32'(cfg1), 32'h0ABC);
        check_eq("chain_fields0", 32'(fields0()), 32'h1555);
        check_eq("chain_fields1", 32'(fields1()), 32'h0ABC);
        check_eq("chain_pulse0",  32'(upd0_cycles - base0), 32'h1);
        check_eq("chain_pulse1",  32'(upd1_cycles - base1), 32'h1);

        // Clear versus load: strobe with clock low clears, keeps cfg_word
        base0 = upd0_cycles;
        send_word(13'h1ABC, 7);
        sck_in = 1'b0;
        step(2);
        srn_in = 1'b0;
        step(6);
        check_eq("clear_cfg0_kept", 32'(cfg0), 32'h1555);
        check_eq("clear_no_pulse",  32'(upd0_cycles - base0), 32'h0);
        check_eq("clear_dout0",     32'(sd0), 32'h0);
        // Raise the clock under reset (no shift), release, then strobe
        sck_in = 1'b1;
        step(2);
        srn_in = 1'b1;
        step(2);
        srn_in = 1'b0;
        step(2);
        sck_in = 1'b0;
        step(2);
        srn_in = 1'b1;
        step(8);
        check_eq("clrload_cfg0",  32'(cfg0), 32'h0000);
        check_eq("clrload_cfg1",  32'(cfg1), 32'h0000);
        check_eq("clrload_pulse", 32'(upd0_cycles - base0), 32'h1);

        // Mid-shift reset
        send_word(13'h1FFF, 5);
        resetn = 1'b0;
        #1;
        check_eq("midrst_cfg0", 32'(cfg0), 32'h0403);
        check_eq("midrst_cfg1", 32'(cfg1), 32'h1803);
        check_eq("midrst_outs", 32'({sck0, sd0, sck1, sd1}), 32'h0);
        sck_in = 1'b0;
        srn_in = 1'b1;
        step(3);
        resetn = 1'b1;
        step(4);
        base0 = upd0_cycles;
        send_word(13'h0001, W);
        step(8);
        load_strobe();
        step(8);
        check_eq("post_rst_cfg0",  32'(cfg0), 32'h0001);
        check_eq("post_rst_cfg1",  32'(cfg1), 32'h0000);
        check_eq("post_rst_pulse", 32'(upd0_cycles - base0), 32'h1);

        // Forwarding latency, per hop and over two hops
        step(4);
        sck_in = 1'b1;
        lat0 = -1;
        lat1 = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (sck0 === 1'b1 && lat0 < 0) lat0 = i;
            if (sck1 === 1'b1 && lat1 < 0) lat1 = i;
        end
        check_eq("clk_lat_hop1", 32'(lat0), 32'd3);
        check_eq("clk_lat_hop2", 32'(lat1), 32'd6);
        sck_in = 1'b0;
        step(8);
        srn_in = 1'b0;
        lat0 = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (srn0 === 1'b0 && lat0 < 0) lat0 = i;
        end
        check_eq("rstn_lat_hop1", 32'(lat0), 32'd3);
        srn_in = 1'b1;
        step(8);

        check_eq("dout_activity",      32'(dout_changes0 > 0), 32'h1);
        check_eq("dout_only_on_fall",  32'(dout_viol), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
